mutative_tag_ctrl: RTL and testbench
====================================

# mutative_tag_ctrl

Parametrised tag/state controller for the mutative cache: holds valid, dirty and tag for every way of every set, performs single-cycle lookups with allocate-on-miss, and lets software change associativity at run time. Total capacity stays fixed. Lowering associativity folds the spare way-index bits into the index as way-group selectors. A mode change triggers a flush sequencer that reports every dirty line through a write-back handshake before the new mode takes effect. It sits between the cache request front-end and the data array and write-back engine.

## Interface
- ADDR_WIDTH, 32, request address width
- LINE_BYTES, 32, bytes per line; OFFSET_BITS = $clog2(LINE_BYTES)
- SETS, 128, physical sets; SET_BITS = $clog2(SETS)
- WAYS, 8, physical ways (power of 2); WAY_IDX_BITS = $clog2(WAYS)
- Derived: TAG_BITS = ADDR_WIDTH - SET_BITS - OFFSET_BITS; MODE_BITS = $clog2(WAY_IDX_BITS+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  high when state RUN and !cfg_valid
- req_addr  in  ADDR_WIDTH  byte address {tag, set, offset}
- req_write  in  1  store: sets dirty on hit or fill
- rsp_valid  out  1  registered response, one cycle after accept
- rsp_hit  out  1  hit indication
- rsp_way  out  WAY_IDX_BITS  hit way or allocated way
- rsp_evict  out  1  allocation displaced a valid dirty line
- rsp_evict_tag  out  TAG_BITS  tag of displaced line (set = request set)
- cfg_valid  in  1  associativity change request
- cfg_ready  out  1  high in RUN
- cfg_assoc  in  MODE_BITS  log2 of active ways per group; values above WAY_IDX_BITS clamp to WAY_IDX_BITS
- mode  out  MODE_BITS  current associativity log2
- flush_busy  out  1  high in FLUSH
- wb_valid  out  1  dirty line reported during flush
- wb_ready  in  1  write-back accept
- wb_tag / wb_set / wb_way  out  TAG_BITS / SET_BITS / WAY_IDX_BITS  location of the reported line

## Operation
- State per (set, way): valid, dirty, tag. State per set: rr counter (WAY_IDX_BITS bits). All held in flops.
- Mode k: group size G = 2^k. Group index g = tag[WAY_IDX_BITS-k-1:0]; it is 0 when k = WAY_IDX_BITS. Group ways are g·G … g·G+G-1. The full tag is stored and compared.
- Lookup compares only ways inside the group.
  - Hit: rsp_way = matching way; if req_write, dirty <= 1.
- Miss allocates a victim:
  - The lowest-index invalid way in the group, else g·G + (rr[set] mod G).
  - The victim is written with valid=1, dirty=req_write, tag=request tag.
  - rr[set] increments (wrapping) on every miss.
  - rsp_evict = old valid && old dirty; rsp_evict_tag = old tag.
- FSM states RUN, FLUSH.
  - RUN → FLUSH on cfg_valid && cfg_ready. Clamped cfg_assoc is latched into pending_mode.
  - FLUSH walks idx = set·WAYS + way from 0 to SETS·WAYS-1.
    - Clean or invalid entry: cleared, idx advances, 1 cycle.
    - Dirty entry: wb_valid=1 with wb_tag/wb_set/wb_way. Held stable until wb_ready. On handshake the entry is cleared and idx advances.
  - After the last idx clears: mode <= pending_mode, all rr <= 0, → RUN.
- No request is accepted in FLUSH. Lookups are never blocked by wb_ready in RUN.

## Timing
- Reset (async, any time including mid-flush):
  - valid/dirty/tag/rr all 0; mode = WAY_IDX_BITS; state RUN.
  - req_ready=1, cfg_ready=1, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_evict=0, rsp_evict_tag=0, wb_valid=0, wb_* = 0, flush_busy=0.
- Request accepted at edge N → response fields valid for cycle N+1 only, no backpressure. Array update occurs at edge N, so the request accepted at N+1 sees it; same-set back-to-back accesses are coherent.
- cfg and req in the same cycle: cfg wins and req_ready=0. flush_busy rises the cycle after the cfg handshake.
- Flush with no dirty lines lasts exactly SETS·WAYS cycles. Each dirty line adds the wb stall cycles. req_ready returns the cycle after the last clear.
- A cfg_assoc equal to the current mode still performs a full flush.

## Test plan
- Reset, then read 0x00001000 (set 0, tag 1) → rsp_hit=0, rsp_way=0, rsp_evict=0. Repeat read → rsp_hit=1, rsp_way=0.
- Mode 3: write 0x1000, then read 0x2000…0x9000 (tags 1–9, set 0) → ways 0–7 filled in order. The 9th miss allocates way 0 with rsp_evict=1, rsp_evict_tag=0x00001.
- Write 0x1000, then cfg_assoc=0 while wb_ready is held low for 5 cycles → wb_valid=1, wb_tag=1, wb_set=0, wb_way=0 stay stable. Handshake follows; flush_busy falls after 1024+5 cycles in total; mode=0.
- Mode 0: read 0x1000 → way 1; read 0x3000 → way 3; write 0x9000 → way 1, miss. Read 0x1000 → miss, rsp_evict=1, rsp_evict_tag=9.
- cfg_assoc=7 → mode=3 after flush. Hold cfg_valid and req_valid together → req_ready=0 that cycle.
- Assert rst_n mid-flush with wb_valid=1 → all outputs take their reset values immediately. Next read of the flushed address misses.

Source files
------------

// File: rtl/mutative_tag_ctrl.sv
// Tag/state controller for the mutative cache: single-cycle lookup with allocate-on-miss,
// plus run-time associativity changes that flush every line and report dirty ones for write-back.
module mutative_tag_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_BYTES   = 32,
  parameter int SETS         = 128,
  parameter int WAYS         = 8,
  // Derived widths; leave at their defaults.
  parameter int OFFSET_BITS  = $clog2(LINE_BYTES),
  parameter int SET_BITS     = $clog2(SETS),
  parameter int WAY_IDX_BITS = $clog2(WAYS),
  parameter int TAG_BITS     = ADDR_WIDTH - SET_BITS - OFFSET_BITS,
  parameter int MODE_BITS    = $clog2(WAY_IDX_BITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [WAY_IDX_BITS-1:0] rsp_way,
  output logic                    rsp_evict,
  output logic [TAG_BITS-1:0]     rsp_evict_tag,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [MODE_BITS-1:0]    cfg_assoc,
  output logic [MODE_BITS-1:0]    mode,
  output logic                    flush_busy,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [TAG_BITS-1:0]     wb_tag,
  output logic [SET_BITS-1:0]     wb_set,
  output logic [WAY_IDX_BITS-1:0] wb_way
);

  localparam int IDX_BITS = SET_BITS + WAY_IDX_BITS;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [WAYS-1:0]         r_valid [SETS];
  logic [WAYS-1:0]         r_dirty [SETS];
  logic [TAG_BITS-1:0]     r_tag   [SETS][WAYS];
  logic [WAY_IDX_BITS-1:0] r_rr    [SETS];
  logic [MODE_BITS-1:0]    r_mode;
  logic [MODE_BITS-1:0]    r_pendingMode;
  logic [IDX_BITS-1:0]     r_flushIdx;

  logic                    r_rspValid;
  logic                    r_rspHit;
  logic [WAY_IDX_BITS-1:0] r_rspWay;
  logic                    r_rspEvict;
  logic [TAG_BITS-1:0]     r_rspEvictTag;

  logic [SET_BITS-1:0]     w_set;
  logic [TAG_BITS-1:0]     w_tag;
  logic [WAY_IDX_BITS-1:0] w_grpMask;
  logic [WAY_IDX_BITS-1:0] w_hiMask;
  logic [WAY_IDX_BITS-1:0] w_lowMask;
  logic [WAY_IDX_BITS-1:0] w_grp;
  logic [WAY_IDX_BITS-1:0] w_base;
  logic [WAYS-1:0]         w_inGrp;
  logic                    w_hit;
  logic [WAY_IDX_BITS-1:0] w_hitWay;
  logic                    w_freeFound;
  logic [WAY_IDX_BITS-1:0] w_freeWay;
  logic [WAY_IDX_BITS-1:0] w_victim;
  logic                    w_evict;
  logic [TAG_BITS-1:0]     w_oldTag;
  logic                    w_accept;
  logic                    w_cfgFire;
  logic [MODE_BITS-1:0]    w_cfgClamped;
  logic [SET_BITS-1:0]     w_flushSet;
  logic [WAY_IDX_BITS-1:0] w_flushWay;
  logic                    w_flushDirty;
  logic                    w_flushClear;
  logic                    w_flushLast;
  logic                    w_unusedOffset;

  assign w_set          = req_addr[OFFSET_BITS +: SET_BITS];
  assign w_tag          = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_unusedOffset = ^req_addr[OFFSET_BITS-1:0];

  // Low tag bits not consumed by the way offset pick the way group in reduced-associativity modes.
  assign w_grpMask = {WAY_IDX_BITS{1'b1}} >> r_mode;
  assign w_hiMask  = {WAY_IDX_BITS{1'b1}} << r_mode;
  assign w_lowMask = ~w_hiMask;
  assign w_grp     = w_tag[WAY_IDX_BITS-1:0] & w_grpMask;
  assign w_base    = w_grp << r_mode;

  always_comb begin
    w_inGrp = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_inGrp[w] = ((WAY_IDX_BITS'(w) >> r_mode) == w_grp);
    end
  end

  always_comb begin
    w_hit       = 1'b0;
    w_hitWay    = '0;
    w_freeFound = 1'b0;
    w_freeWay   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_inGrp[w] && r_valid[w_set][w] && (r_tag[w_set][w] == w_tag) && !w_hit) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_IDX_BITS'(w);
      end
      if (w_inGrp[w] && !r_valid[w_set][w] && !w_freeFound) begin
        w_freeFound = 1'b1;
        w_freeWay   = WAY_IDX_BITS'(w);
      end
    end
  end

  assign w_victim = w_freeFound ? w_freeWay : (w_base | (r_rr[w_set] & w_lowMask));
  assign w_oldTag = r_tag[w_set][w_victim];
  assign w_evict  = !w_hit && r_valid[w_set][w_victim] && r_dirty[w_set][w_victim];

  assign w_cfgFire    = cfg_valid && (r_state == ST_RUN);
  assign w_accept     = req_valid && (r_state == ST_RUN) && !cfg_valid;
  assign w_cfgClamped = (cfg_assoc > MODE_BITS'(WAY_IDX_BITS)) ? MODE_BITS'(WAY_IDX_BITS) : cfg_assoc;

  assign w_flushSet   = r_flushIdx[IDX_BITS-1 -: SET_BITS];
  assign w_flushWay   = r_flushIdx[WAY_IDX_BITS-1:0];
  assign w_flushDirty = r_valid[w_flushSet][w_flushWay] && r_dirty[w_flushSet][w_flushWay];
  assign w_flushClear = (r_state == ST_FLUSH) && (!w_flushDirty || wb_ready);
  assign w_flushLast  = (r_flushIdx == IDX_BITS'(SETS * WAYS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN:   if (cfg_valid) w_nextState = ST_FLUSH;
      ST_FLUSH: if (w_flushClear && w_flushLast) w_nextState = ST_RUN;
      default:  w_nextState = ST_RUN;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_RUN) && !cfg_valid;
    cfg_ready  = (r_state == ST_RUN);
    flush_busy = (r_state == ST_FLUSH);
    wb_valid   = (r_state == ST_FLUSH) && w_flushDirty;
    wb_tag     = '0;
    wb_set     = '0;
    wb_way     = '0;
    if (wb_valid) begin
      wb_tag = r_tag[w_flushSet][w_flushWay];
      wb_set = w_flushSet;
      wb_way = w_flushWay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_BITS'(WAY_IDX_BITS);
      r_pendingMode <= MODE_BITS'(WAY_IDX_BITS);
      r_flushIdx    <= '0;
    end else if (w_cfgFire) begin
      r_pendingMode <= w_cfgClamped;
      r_flushIdx    <= '0;
    end else if (w_flushClear) begin
      r_flushIdx <= r_flushIdx + 1'b1;
      if (w_flushLast) r_mode <= r_pendingMode;
    end
  end

  // The new mode only takes effect once every entry is cleared, so old and new layouts never mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
        for (int w = 0; w < WAYS; w++) r_tag[s][w] <= '0;
      end
    end else if (w_accept) begin
      if (w_hit) begin
        if (req_write) r_dirty[w_set][w_hitWay] <= 1'b1;
      end else begin
        r_valid[w_set][w_victim] <= 1'b1;
        r_dirty[w_set][w_victim] <= req_write;
        r_tag[w_set][w_victim]   <= w_tag;
        r_rr[w_set]              <= r_rr[w_set] + 1'b1;
      end
    end else if (w_flushClear) begin
      r_valid[w_flushSet][w_flushWay] <= 1'b0;
      r_dirty[w_flushSet][w_flushWay] <= 1'b0;
      r_tag[w_flushSet][w_flushWay]   <= '0;
      if (w_flushLast) begin
        for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid    <= 1'b0;
      r_rspHit      <= 1'b0;
      r_rspWay      <= '0;
      r_rspEvict    <= 1'b0;
      r_rspEvictTag <= '0;
    end else begin
      r_rspValid    <= w_accept;
      r_rspHit      <= w_accept && w_hit;
      r_rspWay      <= w_accept ? (w_hit ? w_hitWay : w_victim) : '0;
      r_rspEvict    <= w_accept && w_evict;
      r_rspEvictTag <= (w_accept && !w_hit) ? w_oldTag : '0;
    end
  end

  assign rsp_valid     = r_rspValid;
  assign rsp_hit       = r_rspHit;
  assign rsp_way       = r_rspWay;
  assign rsp_evict     = r_rspEvict;
  assign rsp_evict_tag = r_rspEvictTag;
  assign mode          = r_mode;

endmodule

// File: tb/tb_mutative_tag_ctrl.sv
// Scoreboard bench for mutative_tag_ctrl: a behavioural cache model predicts every response
// and every write-back, which monitors compare against the DUT.
module tb_mutative_tag_ctrl;

  localparam int ADDR_WIDTH   = 32;
  localparam int LINE_BYTES   = 32;
  localparam int SETS         = 128;
  localparam int WAYS         = 8;
  localparam int OFFSET_BITS  = 5;
  localparam int SET_BITS     = 7;
  localparam int WAY_IDX_BITS = 3;
  localparam int TAG_BITS     = 20;
  localparam int MODE_BITS    = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic                    rsp_valid;
  logic                    rsp_hit;
  logic [WAY_IDX_BITS-1:0] rsp_way;
  logic                    rsp_evict;
  logic [TAG_BITS-1:0]     rsp_evict_tag;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [MODE_BITS-1:0]    cfg_assoc;
  logic [MODE_BITS-1:0]    mode;
  logic                    flush_busy;
  logic                    wb_valid;
  logic                    wb_ready;
  logic [TAG_BITS-1:0]     wb_tag;
  logic [SET_BITS-1:0]     wb_set;
  logic [WAY_IDX_BITS-1:0] wb_way;

  mutative_tag_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_assoc(cfg_assoc), .mode(mode),
    .flush_busy(flush_busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_tag(wb_tag), .wb_set(wb_set), .wb_way(wb_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int way;
    bit evict;
    int etag;
  } rsp_t;

  typedef struct {
    int tag;
    int set;
    int way;
  } wb_t;

  rsp_t rspQ[$];
  wb_t  wbQ[$];

  bit mValid [SETS][WAYS];
  bit mDirty [SETS][WAYS];
  int mTag   [SETS][WAYS];
  int mRr    [SETS];
  int mMode;

  int passCount;
  int checkCount;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      mRr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mValid[s][w] = 0;
        mDirty[s][w] = 0;
        mTag[s][w]   = 0;
      end
    end
    mMode = WAY_IDX_BITS;
    rspQ.delete();
    wbQ.delete();
  endtask

  task automatic modelAccess(input bit [31:0] addr, input bit wr, output rsp_t r);
    int s, t, gsz, base, v;
    s    = int'((addr >> OFFSET_BITS) % SETS);
    t    = int'(addr >> (OFFSET_BITS + SET_BITS));
    gsz  = 1 << mMode;
    base = (t % (WAYS / gsz)) * gsz;
    r    = '{hit: 0, way: 0, evict: 0, etag: 0};
    for (int j = 0; j < gsz; j++) begin
      if (mValid[s][base+j] && mTag[s][base+j] == t) begin
        r.hit = 1;
        r.way = base + j;
      end
    end
    if (r.hit) begin
      if (wr) mDirty[s][r.way] = 1;
    end else begin
      v = -1;
      for (int j = gsz - 1; j >= 0; j--) if (!mValid[s][base+j]) v = base + j;
      if (v < 0) v = base + (mRr[s] % gsz);
      r.way   = v;
      r.evict = mValid[s][v] && mDirty[s][v];
      r.etag  = mTag[s][v];
      mValid[s][v] = 1;
      mDirty[s][v] = wr;
      mTag[s][v]   = t;
      mRr[s]       = (mRr[s] + 1) % WAYS;
    end
  endtask

  // Response monitor: every response must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checkOutput("rspExpected", 64'(rspQ.size() != 0), 64'd1);
      if (rspQ.size() != 0) begin
        rsp_t e;
        e = rspQ.pop_front();
        checkOutput("rspHit", rsp_hit, e.hit);
        checkOutput("rspWay", rsp_way, e.way);
        checkOutput("rspEvict", rsp_evict, e.evict);
        if (e.evict) checkOutput("rspEvictTag", rsp_evict_tag, e.etag);
      end
    end
  end

  // Called just after a rising edge; leaves the bench just after the accepting edge.
  task automatic applyStimulus(input bit [31:0] addr, input bit wr);
    rsp_t e;
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    @(negedge clk);
    if (req_ready) begin
      modelAccess(addr, wr, e);
      rspQ.push_back(e);
    end else begin
      checkOutput("reqReady", req_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic expectRsp(input string name, input bit hit, input int way, input bit evict, input int etag);
    @(negedge clk);
    checkOutput({name, ".valid"}, rsp_valid, 1'b1);
    checkOutput({name, ".hit"}, rsp_hit, hit);
    checkOutput({name, ".way"}, rsp_way, way);
    checkOutput({name, ".evict"}, rsp_evict, evict);
    if (evict) checkOutput({name, ".evictTag"}, rsp_evict_tag, etag);
    @(posedge clk);
    #1;
  endtask

  task automatic doFlush(input int assoc, input int stall, input bit withReq);
    int dirtyCount, cycles, cnt, limit;
    logic [MODE_BITS-1:0] a;
    a          = MODE_BITS'(assoc);
    cfg_valid  = 1'b1;
    cfg_assoc  = a;
    if (withReq) begin
      req_valid = 1'b1;
      req_addr  = 32'h0000_1000;
    end
    @(negedge clk);
    checkOutput("cfgReady", cfg_ready, 1'b1);
    if (withReq) checkOutput("reqBlockedByCfg", req_ready, 1'b0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    req_valid = 1'b0;
    dirtyCount = 0;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mValid[s][w] && mDirty[s][w]) begin
          wbQ.push_back('{tag: mTag[s][w], set: s, way: w});
          dirtyCount++;
        end
        mValid[s][w] = 0;
        mDirty[s][w] = 0;
        mTag[s][w]   = 0;
      end
      mRr[s] = 0;
    end
    mMode = (int'(a) > WAY_IDX_BITS) ? WAY_IDX_BITS : int'(a);
    limit = SETS * WAYS + stall * dirtyCount + 16;
    cycles = 0;
    cnt = 0;
    @(negedge clk);
    checkOutput("flushBusyRise", flush_busy, 1'b1);
    while (flush_busy && cycles < limit) begin
      if (wb_valid) begin
        checkOutput("wbExpected", 64'(wbQ.size() != 0), 64'd1);
        if (wbQ.size() != 0) begin
          checkOutput("wbTag", wb_tag, wbQ[0].tag);
          checkOutput("wbSet", wb_set, wbQ[0].set);
          checkOutput("wbWay", wb_way, wbQ[0].way);
        end
        if (cnt >= stall) begin
          wb_ready = 1'b1;
          cnt = 0;
          if (wbQ.size() != 0) void'(wbQ.pop_front());
        end else begin
          wb_ready = 1'b0;
          cnt++;
        end
      end else begin
        wb_ready = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    wb_ready = 1'b0;
    checkOutput("flushCycles", cycles, SETS * WAYS + stall * dirtyCount);
    checkOutput("wbAllReported", wbQ.size(), 0);
    checkOutput("modeAfterFlush", mode, mMode);
    checkOutput("reqReadyAfterFlush", req_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #7;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic randomBurst(input int n);
    bit [31:0] addr;
    for (int i = 0; i < n; i++) begin
      addr = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
      applyStimulus(addr, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_assoc  = '0;
    wb_ready   = 1'b0;
    modelReset();
    #23;
    checkOutput("resetReqReady", req_ready, 1'b1);
    checkOutput("resetCfgReady", cfg_ready, 1'b1);
    checkOutput("resetRspValid", rsp_valid, 1'b0);
    checkOutput("resetMode", mode, WAY_IDX_BITS);
    checkOutput("resetFlushBusy", flush_busy, 1'b0);
    checkOutput("resetWbValid", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(32'h0000_1000, 1'b0);
    expectRsp("firstRead", 1'b0, 0, 1'b0, 0);
    applyStimulus(32'h0000_1000, 1'b0);
    expectRsp("repeatRead", 1'b1, 0, 1'b0, 0);

    applyStimulus(32'h0000_1000, 1'b1);
    for (int t = 2; t <= 8; t++) applyStimulus(32'(t) << 12, 1'b0);
    applyStimulus(32'h0000_9000, 1'b0);
    expectRsp("ninthMiss", 1'b0, 0, 1'b1, 1);

    doReset();
    applyStimulus(32'h0000_1000, 1'b1);
    doFlush(0, 5, 1'b0);

    applyStimulus(32'h0000_1000, 1'b0);
    expectRsp("dmRead1", 1'b0, 1, 1'b0, 0);
    applyStimulus(32'h0000_3000, 1'b0);
    expectRsp("dmRead3", 1'b0, 3, 1'b0, 0);
    applyStimulus(32'h0000_9000, 1'b1);
    expectRsp("dmWrite9", 1'b0, 1, 1'b0, 0);
    applyStimulus(32'h0000_1000, 1'b0);
    expectRsp("dmConflict", 1'b0, 1, 1'b1, 9);

    doFlush(7, 0, 1'b1);

    randomBurst(40);
    doFlush(1, 1, 1'b0);
    randomBurst(40);
    doFlush(2, 2, 1'b0);
    randomBurst(40);
    doFlush(3, 0, 1'b0);

    applyStimulus(32'h0000_1000, 1'b1);
    cfg_valid = 1'b1;
    cfg_assoc = 2'd2;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    n = 0;
    while (!wb_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wbBeforeReset", wb_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetWbValid", wb_valid, 1'b0);
    checkOutput("midResetWbTag", wb_tag, 0);
    checkOutput("midResetWbWay", wb_way, 0);
    checkOutput("midResetFlushBusy", flush_busy, 1'b0);
    checkOutput("midResetReqReady", req_ready, 1'b1);
    checkOutput("midResetCfgReady", cfg_ready, 1'b1);
    checkOutput("midResetMode", mode, WAY_IDX_BITS);
    checkOutput("midResetRspValid", rsp_valid, 1'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_1000, 1'b0);
    expectRsp("afterMidReset", 1'b0, 0, 1'b0, 0);

    repeat (3) @(negedge clk);
    checkOutput("rspAllSeen", rspQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
